stage_execute: RTL

- Execute stage of the 5-stage pipeline, directly downstream of decode.
- Consumes decoded operands, ALU opcode and destination register; produces a registered result for the memory stage.
- Contains single-cycle ALU ops plus an iterative multiply/divide unit with architectural HI/LO registers.
- Raises a stall request while a multi-cycle operation is in flight.

---
 rtl/stage_execute_if.sv | 31 +++
 rtl/stage_execute.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_execute_if.sv
// rtl/stage_execute_if.sv - decode/execute/memory handshake bundle for the execute stage
interface stage_execute_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             nullify;
  logic             in_valid;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic [4:0]       dest_reg_in;
  logic             write_reg_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       dest_reg;
  logic             write_reg;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output stall, nullify, in_valid, op, a, b, shamt, dest_reg_in, write_reg_in,
    input  out_valid, result, dest_reg, write_reg, busy, hi, lo
  );

  modport slave (
    input  stall, nullify, in_valid, op, a, b, shamt, dest_reg_in, write_reg_in,
    output out_valid, result, dest_reg, write_reg, busy, hi, lo
  );
endinterface

// File: rtl/stage_execute.sv
// rtl/stage_execute.sv - pipeline execute stage with ALU and iterative mul/div (optional FAST_MULT_EN)
module stage_execute #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input logic            clk,
  input logic            reset,
  stage_execute_if.slave ex
);
  localparam int           CW   = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_MULT  = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_MFHI  = 5'd15;
  localparam logic [4:0] OP_MFLO  = 5'd16;
  localparam logic [4:0] OP_MTHI  = 5'd17;
  localparam logic [4:0] OP_MTLO  = 5'd18;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic [4:0]       dest_reg_reg;
  logic             write_reg_reg;
  logic             busy_sig;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // Iterative unit: md_a is multiplicand/divisor magnitude, {md_hi,md_lo} is the
  // product shift pair or remainder/quotient pair.
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [CW-1:0]    md_count;
  logic             md_is_div;
  logic             md_neg_q;
  logic             md_neg_r;
  logic             md_div_zero;

  logic             accept;
  logic             op_mul;
  logic             op_div;
  logic             op_signed;
  logic             md_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] alu_result;
  logic             alu_write;
  logic             alu_valid;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_final;
  logic [WIDTH-1:0]   lo_final;

  assign accept    = ex.in_valid && !ex.stall && !ex.nullify && (state == IDLE);
  assign op_mul    = (ex.op == OP_MULT) || (ex.op == OP_MULTU);
  assign op_div    = (ex.op == OP_DIV) || (ex.op == OP_DIVU);
  assign op_signed = (ex.op == OP_MULT) || (ex.op == OP_DIV);
  assign a_mag     = (op_signed && ex.a[WIDTH-1]) ? -ex.a : ex.a;
  assign b_mag     = (op_signed && ex.b[WIDTH-1]) ? -ex.b : ex.b;

`ifdef FAST_MULT_EN
  logic signed [2*WIDTH-1:0] fast_sprod;
  logic        [2*WIDTH-1:0] fast_uprod;
  logic        [2*WIDTH-1:0] fast_prod;
  assign md_iter    = op_div;
  assign fast_sprod = $signed(ex.a) * $signed(ex.b);
  assign fast_uprod = {{WIDTH{1'b0}}, ex.a} * {{WIDTH{1'b0}}, ex.b};
  assign fast_prod  = (ex.op == OP_MULT) ? $unsigned(fast_sprod) : fast_uprod;
`else
  assign md_iter = op_mul || op_div;
`endif

  // Single-cycle ALU result and write enable for the instruction at issue
  always_comb begin
    alu_result = '0;
    alu_write  = ex.write_reg_in;
    alu_valid  = 1'b1;
    case (ex.op)
      OP_ADD:   alu_result = ex.a + ex.b;
      OP_SUB:   alu_result = ex.a - ex.b;
      OP_AND:   alu_result = ex.a & ex.b;
      OP_OR:    alu_result = ex.a | ex.b;
      OP_XOR:   alu_result = ex.a ^ ex.b;
      OP_NOR:   alu_result = ~(ex.a | ex.b);
      OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(ex.a) < $signed(ex.b))};
      OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (ex.a < ex.b)};
      OP_SLL:   alu_result = ex.b << ex.shamt;
      OP_SRL:   alu_result = ex.b >> ex.shamt;
      OP_SRA:   alu_result = $unsigned($signed(ex.b) >>> ex.shamt);
      OP_MFHI:  alu_result = hi_reg;
      OP_MFLO:  alu_result = lo_reg;
      OP_MTHI, OP_MTLO: begin
        alu_result = ex.a;
        alu_write  = 1'b0;
      end
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        alu_write = 1'b0;
        alu_valid = 1'b0;
      end
      default:  alu_write = 1'b0;
    endcase
  end

  // One shift-add or restoring-subtract step and the sign-corrected final HI/LO
  always_comb begin
    mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_a} : {(WIDTH+1){1'b0}});
    div_shift = {md_hi, md_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, md_a};
    prod      = {md_hi, md_lo};
    prod_fix  = md_neg_q ? -prod : prod;
    hi_final  = prod_fix[2*WIDTH-1:WIDTH];
    lo_final  = prod_fix[WIDTH-1:0];
    if (md_is_div) begin
      if (md_div_zero) begin
        hi_final = md_a;
        lo_final = '1;
      end else begin
        hi_final = md_neg_r ? -md_hi : md_hi;
        lo_final = md_neg_q ? -md_lo : md_lo;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state; stall freezes, nullify aborts and overrides stall
  always_comb begin
    state_next = state;
    busy_sig   = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept && md_iter) state_next = op_div ? DIV : MUL;
      end
      MUL, DIV: begin
        if (ex.nullify)                          state_next = IDLE;
        else if (!ex.stall && md_count == LAST)  state_next = DONE;
      end
      DONE: begin
        if (ex.nullify || !ex.stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result register toward the memory stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      dest_reg_reg  <= '0;
      write_reg_reg <= 1'b0;
    end else if (ex.nullify) begin
      out_valid_reg <= 1'b0;
      write_reg_reg <= 1'b0;
    end else if (!ex.stall) begin
      if (accept) begin
        out_valid_reg <= alu_valid;
        result_reg    <= alu_result;
        dest_reg_reg  <= ex.dest_reg_in;
        write_reg_reg <= alu_write;
      end else begin
        out_valid_reg <= 1'b0;
        write_reg_reg <= 1'b0;
      end
    end
  end

  // Architectural HI/LO: moves at issue, mul/div results on leaving DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (!ex.nullify && !ex.stall) begin
      if (accept && ex.op == OP_MTHI) hi_reg <= ex.a;
      if (accept && ex.op == OP_MTLO) lo_reg <= ex.a;
`ifdef FAST_MULT_EN
      if (accept && op_mul) begin
        hi_reg <= fast_prod[2*WIDTH-1:WIDTH];
        lo_reg <= fast_prod[WIDTH-1:0];
      end
`endif
      if (state == DONE) begin
        hi_reg <= hi_final;
        lo_reg <= lo_final;
      end
    end
  end

  // Iterative mul/div datapath: operand setup at accept, one step per unstalled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_a        <= '0;
      md_hi       <= '0;
      md_lo       <= '0;
      md_count    <= '0;
      md_is_div   <= 1'b0;
      md_neg_q    <= 1'b0;
      md_neg_r    <= 1'b0;
      md_div_zero <= 1'b0;
    end else if (!ex.nullify && !ex.stall) begin
      if (accept && md_iter) begin
        md_hi     <= '0;
        md_count  <= '0;
        md_is_div <= op_div;
        md_neg_q  <= op_signed && (ex.a[WIDTH-1] ^ ex.b[WIDTH-1]);
        if (op_div) begin
          // A zero divisor leaves md_a free, so it keeps the raw dividend for HI.
          md_a        <= (ex.b == '0) ? ex.a : b_mag;
          md_lo       <= a_mag;
          md_neg_r    <= op_signed && ex.a[WIDTH-1];
          md_div_zero <= (ex.b == '0);
        end else begin
          md_a        <= a_mag;
          md_lo       <= b_mag;
          md_neg_r    <= 1'b0;
          md_div_zero <= 1'b0;
        end
      end else if (state == MUL) begin
        md_hi    <= mul_sum[WIDTH:1];
        md_lo    <= {mul_sum[0], md_lo[WIDTH-1:1]};
        md_count <= md_count + CW'(1);
      end else if (state == DIV) begin
        if (!div_diff[WIDTH]) begin
          md_hi <= div_diff[WIDTH-1:0];
          md_lo <= {md_lo[WIDTH-2:0], 1'b1};
        end else begin
          md_hi <= div_shift[WIDTH-1:0];
          md_lo <= {md_lo[WIDTH-2:0], 1'b0};
        end
        md_count <= md_count + CW'(1);
      end
    end
  end

  assign ex.out_valid = out_valid_reg;
  assign ex.result    = result_reg;
  assign ex.dest_reg  = dest_reg_reg;
  assign ex.write_reg = write_reg_reg;
  assign ex.busy      = busy_sig;
  assign ex.hi        = hi_reg;
  assign ex.lo        = lo_reg;
endmodule
